// File: rtl/rbm_result_reader_pkg.sv
// Shared defaults, FSM state encoding and vote-vector slice helpers for the RBM result reader.
`ifndef RBM_RESULT_READER_PKG_MACROS
`define RBM_RESULT_READER_PKG_MACROS
`define RBM_PORT(w) logic [(w)-1:0]
`define RBM_GET(vec, i, w) vec[(i)*(w) +: (w)]
`endif

package rbm_result_reader_pkg;

    localparam int unsigned DEFAULT_BITLENGTH     = 12;
    localparam int unsigned DEFAULT_OUTPUT_DIM    = 10;
    localparam int unsigned DEFAULT_ITERATION_NUM = 100;
    localparam int unsigned DEFAULT_LABEL_WIDTH   = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SCAN  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/rbm_vote_compare.sv
// Compares one class count against the running best; optional runner-up tracking
// is present only when RESULT_MARGIN_EN is defined.
module rbm_vote_compare
    import rbm_result_reader_pkg::*;
#(
    parameter int unsigned bitlength = DEFAULT_BITLENGTH
) (
    input  `RBM_PORT(bitlength) count,
    input  `RBM_PORT(bitlength) best_cnt,
    output logic                update_c
`ifdef RESULT_MARGIN_EN
    ,
    input  `RBM_PORT(bitlength) runner_cnt,
    output `RBM_PORT(bitlength) runner_next_c
`endif
);

    // Strict compare keeps the lowest index on ties.
    assign update_c = (count > best_cnt);

`ifdef RESULT_MARGIN_EN
    // A new winner demotes the old best; an equal count lifts the runner-up to the best.
    always_comb begin
        runner_next_c = runner_cnt;
        if (update_c) begin
            runner_next_c = best_cnt;
        end else if (count > runner_cnt) begin
            runner_next_c = count;
        end
    end
`endif

endmodule

// File: rtl/rbm_result_reader.sv
// Runs the RBM core for one image, snapshots its per-class votes and scans them for the argmax.
// Optional feature macro: RESULT_MARGIN_EN adds the winner-minus-runner-up margin output.
module rbm_result_reader
    import rbm_result_reader_pkg::*;
#(
    parameter int unsigned bitlength     = DEFAULT_BITLENGTH,
    parameter int unsigned output_dim    = DEFAULT_OUTPUT_DIM,
    parameter int unsigned iteration_num = DEFAULT_ITERATION_NUM,
    parameter int unsigned label_width   = DEFAULT_LABEL_WIDTH
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             start,
    output logic                             start_ready,
    output logic                             rbm_reset,
    input  logic                             rbm_finish,
    input  logic [output_dim*bitlength-1:0]  VoteData,
    output logic [label_width-1:0]           label,
    output logic [bitlength-1:0]             label_votes,
    output logic                             vote_error,
    output logic                             result_valid,
    input  logic                             result_ready
`ifdef RESULT_MARGIN_EN
    ,
    output logic [bitlength-1:0]             margin
`endif
);

    localparam int unsigned SUM_W = bitlength + label_width;

    state_t                 state_q, state_d;
    logic                   start_ready_d, rbm_reset_d, result_valid_d;

    logic [bitlength-1:0]   snap_q [output_dim];
    logic [label_width-1:0] idx_q;
    logic [SUM_W-1:0]       sum_q;
    logic [bitlength-1:0]   best_cnt_q;
    logic [label_width-1:0] best_idx_q;

    logic [bitlength-1:0]   cur_c;
    logic [bitlength-1:0]   best_next_c;
    logic [SUM_W-1:0]       sum_next_c;
    logic                   upd_c;
    logic                   last_c;

`ifdef RESULT_MARGIN_EN
    logic [bitlength-1:0]   runner_q;
    logic [bitlength-1:0]   runner_next_c;
`endif

    assign cur_c       = snap_q[idx_q];
    assign last_c      = (idx_q == label_width'(output_dim - 1));
    assign sum_next_c  = sum_q + SUM_W'(cur_c);
    assign best_next_c = upd_c ? cur_c : best_cnt_q;

    rbm_vote_compare #(
        .bitlength (bitlength)
    ) u_vote_compare (
        .count         (cur_c),
        .best_cnt      (best_cnt_q),
        .update_c      (upd_c)
`ifdef RESULT_MARGIN_EN
        ,
        .runner_cnt    (runner_q),
        .runner_next_c (runner_next_c)
`endif
    );

    // Next state and next values of the registered handshake/control outputs.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start)                       state_d = ST_CLEAR;
            ST_CLEAR:                                  state_d = ST_WAIT;
            ST_WAIT:  if (rbm_finish)                  state_d = ST_SCAN;
            ST_SCAN:  if (last_c)                      state_d = ST_HOLD;
            ST_HOLD:  if (result_valid && result_ready) state_d = ST_IDLE;
            default:                                   state_d = ST_IDLE;
        endcase
        start_ready_d  = (state_d == ST_IDLE);
        rbm_reset_d    = (state_d != ST_WAIT);
        result_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            start_ready  <= 1'b1;
            rbm_reset    <= 1'b1;
            result_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_ready  <= start_ready_d;
            rbm_reset    <= rbm_reset_d;
            result_valid <= result_valid_d;
        end
    end

    // Snapshot, accumulate and argmax datapath; results latch on the last scan step.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(output_dim); i++) begin
                snap_q[i] <= '0;
            end
            idx_q       <= '0;
            sum_q       <= '0;
            best_cnt_q  <= '0;
            best_idx_q  <= '0;
            label       <= '0;
            label_votes <= '0;
            vote_error  <= 1'b0;
`ifdef RESULT_MARGIN_EN
            runner_q    <= '0;
            margin      <= '0;
`endif
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    idx_q      <= '0;
                    sum_q      <= '0;
                    best_cnt_q <= '0;
                    best_idx_q <= '0;
`ifdef RESULT_MARGIN_EN
                    runner_q   <= '0;
`endif
                end
                ST_WAIT: begin
                    if (rbm_finish) begin
                        for (int i = 0; i < int'(output_dim); i++) begin
                            snap_q[i] <= `RBM_GET(VoteData, i, bitlength);
                        end
                        idx_q <= '0;
                    end
                end
                ST_SCAN: begin
                    sum_q      <= sum_next_c;
                    best_cnt_q <= best_next_c;
                    if (upd_c) begin
                        best_idx_q <= idx_q;
                    end
                    idx_q <= idx_q + label_width'(1);
`ifdef RESULT_MARGIN_EN
                    runner_q <= runner_next_c;
`endif
                    if (last_c) begin
                        label       <= upd_c ? idx_q : best_idx_q;
                        label_votes <= best_next_c;
                        vote_error  <= (sum_next_c != SUM_W'(iteration_num));
`ifdef RESULT_MARGIN_EN
                        margin      <= best_next_c - runner_next_c;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rbm_result_reader.sv
// Self-checking bench for rbm_result_reader: vector table plus scoreboard queue and corner-case sequences.
module tb_rbm_result_reader;
    import rbm_result_reader_pkg::*;

    localparam int unsigned BL = 12;
    localparam int unsigned OD = 10;
    localparam int unsigned LW = 4;
    localparam int unsigned IT = 100;
    localparam int unsigned VW = OD * BL;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic          start_ready;
    logic          rbm_reset;
    logic          rbm_finish;
    logic [VW-1:0] VoteData;
    logic [LW-1:0] label;
    logic [BL-1:0] label_votes;
    logic          vote_error;
    logic          result_valid;
    logic          result_ready;
`ifdef RESULT_MARGIN_EN
    logic [BL-1:0] margin;
`endif

    typedef struct {
        logic [VW-1:0] votes;
        int            exp_label;
        int            exp_votes;
        int            exp_err;
        int            exp_margin;
        int            hold;
    } vec_t;

    typedef struct {
        int lbl;
        int votes;
        int err;
        int mrg;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[9];
    int   n_vec  = 0;
    int   n_miss = 0;

    rbm_result_reader #(
        .bitlength     (BL),
        .output_dim    (OD),
        .iteration_num (IT),
        .label_width   (LW)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .start_ready  (start_ready),
        .rbm_reset    (rbm_reset),
        .rbm_finish   (rbm_finish),
        .VoteData     (VoteData),
        .label        (label),
        .label_votes  (label_votes),
        .vote_error   (vote_error),
        .result_valid (result_valid),
        .result_ready (result_ready)
`ifdef RESULT_MARGIN_EN
        ,
        .margin       (margin)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] put(input logic [VW-1:0] v, input int i, input int c);
        logic [VW-1:0] r;
        r = v;
        r[i*BL +: BL] = BL'(c);
        return r;
    endfunction

    // Launches one classification, plays the core, and checks latency, result and hold behaviour.
    task automatic run_vec(input vec_t v);
        int   k;
        int   lat;
        exp_t e;
        k = 0;
        while (!start_ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        check("start_ready_before_start", longint'(start_ready), 1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("clear_rbm_reset", longint'(rbm_reset), 1);
        check("clear_start_ready", longint'(start_ready), 0);
        @(negedge clock);
        check("wait_rbm_reset", longint'(rbm_reset), 0);
        result_ready = 1'b1;
        repeat (2) @(negedge clock);
        result_ready = 1'b0;
        check("wait_no_early_valid", longint'(result_valid), 0);
        check("wait_ready_no_effect", longint'(rbm_reset), 0);
        VoteData   = v.votes;
        rbm_finish = 1'b1;
        sb.push_back('{v.exp_label, v.exp_votes, v.exp_err, v.exp_margin});
        @(negedge clock);
        check("scan_rbm_reset", longint'(rbm_reset), 1);
        rbm_finish = 1'b0;
        VoteData   = ~v.votes;
        lat = 1;
        while (!result_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check("result_latency", lat, OD + 1);
        e = sb.pop_front();
        if (!result_valid) begin
            reset_n = 1'b0;
            @(negedge clock);
            reset_n = 1'b1;
            @(negedge clock);
            return;
        end
        check("label", longint'(label), e.lbl);
        check("label_votes", longint'(label_votes), e.votes);
        check("vote_error", longint'(vote_error), e.err);
`ifdef RESULT_MARGIN_EN
        check("margin", longint'(margin), e.mrg);
`endif
        for (int h = 0; h < v.hold; h++) begin
            start = 1'b1;
            @(negedge clock);
            check("hold_valid", longint'(result_valid), 1);
            check("hold_label", longint'(label), e.lbl);
            check("hold_votes", longint'(label_votes), e.votes);
            check("hold_start_ready", longint'(start_ready), 0);
        end
        start        = 1'b0;
        result_ready = 1'b1;
        @(negedge clock);
        result_ready = 1'b0;
        check("after_hs_valid", longint'(result_valid), 0);
        check("after_hs_start_ready", longint'(start_ready), 1);
    endtask

    initial begin
        logic [VW-1:0] v;
        reset_n      = 1'b0;
        start        = 1'b0;
        rbm_finish   = 1'b0;
        result_ready = 1'b0;
        VoteData     = '0;
        repeat (3) @(negedge clock);
        check("rst_start_ready", longint'(start_ready), 1);
        check("rst_rbm_reset", longint'(rbm_reset), 1);
        check("rst_label", longint'(label), 0);
        check("rst_label_votes", longint'(label_votes), 0);
        check("rst_vote_error", longint'(vote_error), 0);
        check("rst_result_valid", longint'(result_valid), 0);
`ifdef RESULT_MARGIN_EN
        check("rst_margin", longint'(margin), 0);
`endif
        reset_n = 1'b1;
        @(negedge clock);

        v = '0; v = put(v, 0, 5); v = put(v, 3, 60); v = put(v, 7, 35);
        tbl[0] = '{v, 3, 60, 0, 25, 20};
        v = '0; v = put(v, 2, 50); v = put(v, 6, 50);
        tbl[1] = '{v, 2, 50, 0, 0, 3};
        v = '0; v = put(v, 1, 40); v = put(v, 5, 59);
        tbl[2] = '{v, 5, 59, 1, 19, 1};
        v = '0;
        tbl[3] = '{v, 0, 0, 1, 0, 0};
        v = '0; v = put(v, 9, 100);
        tbl[4] = '{v, 9, 100, 0, 100, 2};
        v = '0; v = put(v, 0, 100);
        tbl[5] = '{v, 0, 100, 0, 100, 0};
        v = '0; v = put(v, 4, 4095);
        tbl[6] = '{v, 4, 4095, 1, 4095, 0};
        v = '1;
        tbl[7] = '{v, 0, 4095, 1, 0, 1};
        v = '0;
        for (int i = 0; i < int'(OD); i++) v = put(v, i, 10);
        tbl[8] = '{v, 0, 10, 0, 0, 0};

        for (int i = 0; i < 9; i++) begin
            run_vec(tbl[i]);
        end

        // A done flag seen while idle must not launch a scan.
        rbm_finish = 1'b1;
        VoteData   = tbl[0].votes;
        repeat (5) @(negedge clock);
        check("idle_finish_no_valid", longint'(result_valid), 0);
        check("idle_finish_start_ready", longint'(start_ready), 1);
        check("idle_finish_rbm_reset", longint'(rbm_reset), 1);
        rbm_finish = 1'b0;
        run_vec(tbl[2]);

        // Asynchronous reset in the middle of the scan.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        VoteData   = tbl[0].votes;
        rbm_finish = 1'b1;
        @(negedge clock);
        rbm_finish = 1'b0;
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midscan_rst_valid", longint'(result_valid), 0);
        check("midscan_rst_rbm_reset", longint'(rbm_reset), 1);
        check("midscan_rst_start_ready", longint'(start_ready), 1);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (15) @(negedge clock);
        check("midscan_no_late_valid", longint'(result_valid), 0);
        run_vec(tbl[1]);

        check("scoreboard_empty", longint'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
